dec_demux: RTL

Input-side router of the decryption system: accepts the encrypted character stream from the system input and delivers it, one character per cycle, to the Caesar, Scytale or ZigZag decryptor chosen by `select`. A small FIFO absorbs characters while the target decryptor reports busy. Messages are framed by `valid_i`: the destination is latched at message start and held until the message has fully drained. This is the counterpart of the output mux that collects decrypted data back from the decryptors.

---
 rtl/dec_demux.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dec_demux.sv
// rtl/dec_demux.sv - input-side router from the source stream to the Caesar/Scytale/ZigZag decryptors
// Optional feature macro: DEC_DEMUX_OVF_FLAG_EN adds the sticky ovf_o drop flag.
module dec_demux #(
   parameter int D_WIDTH    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         select,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic               valid_i,
   output logic               busy_o,
   output logic [D_WIDTH-1:0] data0_o,
   output logic               valid0_o,
   output logic [D_WIDTH-1:0] data1_o,
   output logic               valid1_o,
   output logic [D_WIDTH-1:0] data2_o,
   output logic               valid2_o,
   input  logic               busy0_i,
   input  logic               busy1_i,
   input  logic               busy2_i
`ifdef DEC_DEMUX_OVF_FLAG_EN
   ,
   output logic               ovf_o
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t             r_state;
   logic [1:0]         r_sel;
   logic [D_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;

   logic               w_full;
   logic               w_empty;
   logic [1:0]         w_dest;
   logic               w_dest_busy;
   logic               w_push;
   logic               w_pop;

   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);

   // On the IDLE entry cycle the destination has not been latched yet, so use select directly.
   assign w_dest  = (r_state == IDLE) ? select : r_sel;
   assign w_push  = valid_i && (r_state != DRAIN) && !w_full && (w_dest != 2'b11);
   assign w_pop   = !w_empty && !w_dest_busy;

   // Busy is decoded purely from registered state so the source sees a clean level.
   assign busy_o  = (r_state == DRAIN) || w_full;

   // Pick the busy input of the latched destination; destination 11 never pops.
   always_comb begin
      w_dest_busy = 1'b1;
      case (r_sel)
         2'b00:   w_dest_busy = busy0_i;
         2'b01:   w_dest_busy = busy1_i;
         2'b10:   w_dest_busy = busy2_i;
         default: w_dest_busy = 1'b1;
      endcase
   end

   // Message framing FSM: latch the destination at message start, hold it until drained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sel   <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               if (valid_i) begin
                  r_state <= STREAM;
                  r_sel   <= select;
               end
            end
            STREAM: begin
               if (!valid_i) r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_empty) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // FIFO storage; contents need no reset because the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered channel outputs: only the latched channel carries the popped head, for one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data0_o  <= '0;
         valid0_o <= 1'b0;
         data1_o  <= '0;
         valid1_o <= 1'b0;
         data2_o  <= '0;
         valid2_o <= 1'b0;
      end else begin
         data0_o  <= '0;
         valid0_o <= 1'b0;
         data1_o  <= '0;
         valid1_o <= 1'b0;
         data2_o  <= '0;
         valid2_o <= 1'b0;
         if (w_pop) begin
            case (r_sel)
               2'b00: begin
                  data0_o  <= r_mem[r_rd_ptr];
                  valid0_o <= 1'b1;
               end
               2'b01: begin
                  data1_o  <= r_mem[r_rd_ptr];
                  valid1_o <= 1'b1;
               end
               2'b10: begin
                  data2_o  <= r_mem[r_rd_ptr];
                  valid2_o <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef DEC_DEMUX_OVF_FLAG_EN
   logic w_drop;

   // Any valid character that is not pushed (full, DRAIN or destination 11) is a drop.
   assign w_drop = valid_i && !w_push;

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n)      ovf_o <= 1'b0;
      else if (w_drop) ovf_o <= 1'b1;
   end
`endif

endmodule
